// File: rtl/load_store_unit_if.sv
// Shared types and the data-memory bus of the load/store unit.
// master = the load/store unit side, slave = the memory side.
package load_store_unit_pkg;
    typedef enum logic [1:0] {
        FUNC_NONE  = 2'd0,
        FUNC_LOAD  = 2'd1,
        FUNC_STORE = 2'd2,
        FUNC_OTHER = 2'd3
    } func_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// Handshake: dmem_req_o rises with all other request fields already valid.
// The fields stay frozen until the first cycle dmem_ack_i=1 is sampled.
// dmem_rdata_i is only meaningful in that ack cycle.
// dmem_ack_i is ignored whenever no request is outstanding.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    dmem_req_o;
    logic                    dmem_we_o;
    logic [ADDR_WIDTH-1:0]   dmem_addr_o;
    logic [DATA_WIDTH/8-1:0] dmem_be_o;
    logic [DATA_WIDTH-1:0]   dmem_wdata_o;
    logic [DATA_WIDTH-1:0]   dmem_rdata_i;
    logic                    dmem_ack_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_rdata_i, dmem_ack_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_rdata_i, dmem_ack_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: computes the effective address, checks alignment and
// size, issues one data-memory transaction with a timeout, and returns a
// lane-extracted, sign/zero-extended load result with a done/err pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  valid_i,
    input  func_t                 func_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    load_store_unit_if.master     dmem,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] res_o,
    output state_t                state_o
);
    localparam int NB        = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(NB);

    // Data mask covering the low (1 << sz) bytes.
    function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] sz);
        logic [DATA_WIDTH-1:0] m;
        case (sz)
            2'd0:    m = DATA_WIDTH'(8'hFF);
            2'd1:    m = DATA_WIDTH'(16'hFFFF);
            2'd2:    m = DATA_WIDTH'(32'hFFFF_FFFF);
            default: m = '1;
        endcase
        return m;
    endfunction

    // Byte-enable pattern for (1 << sz) bytes starting at lane 0.
    function automatic logic [NB-1:0] be_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        case (sz)
            2'd0:    m = NB'(1);
            2'd1:    m = NB'(3);
            2'd2:    m = NB'(15);
            default: m = '1;
        endcase
        return m;
    endfunction

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NB-1:0]         be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;

    logic [DATA_WIDTH-1:0] eff_full;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [LANE_BITS-1:0]  lane_in;
    logic                  misaligned;
    logic                  oversize;
    logic                  acc_err;
    logic [NB-1:0]         be_new;
    logic [DATA_WIDTH-1:0] wdata_new;
    logic [DATA_WIDTH-1:0] rd_shifted;
    logic                  rd_sign;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  accept;

    // Decode the incoming request: address, legality, lanes and write data.
    always_comb begin
        eff_full = rs1_data_i + imm_i;
        eff_addr = ADDR_WIDTH'(eff_full);
        lane_in  = eff_addr[LANE_BITS-1:0];
        case (size_i)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = eff_addr[0];
            2'd2:    misaligned = |eff_addr[1:0];
            default: misaligned = |eff_addr[2:0];
        endcase
        oversize  = int'(size_i) > LANE_BITS;
        acc_err   = misaligned || oversize;
        be_new    = be_mask(size_i) << lane_in;
        wdata_new = (rs2_data_i & size_mask(size_i)) << {lane_in, 3'b000};
        accept    = valid_i && ((func_i == FUNC_LOAD) || (func_i == FUNC_STORE));
    end

    // Pull the addressed lanes of read data down to bit 0 and extend them.
    always_comb begin
        rd_shifted = dmem.dmem_rdata_i >> {addr_q[LANE_BITS-1:0], 3'b000};
        case (size_q)
            2'd0:    rd_sign = rd_shifted[7];
            2'd1:    rd_sign = rd_shifted[15];
            2'd2:    rd_sign = rd_shifted[31];
            default: rd_sign = rd_shifted[DATA_WIDTH-1];
        endcase
        load_val = (rd_shifted & size_mask(size_q))
                 | ((rd_sign && !uns_q) ? ~size_mask(size_q) : '0);
    end

    // Next-state and registered-output logic of the IDLE/WAIT/RESP FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        res_d   = res_q;
        size_d  = size_q;
        uns_d   = uns_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    size_d = size_i;
                    uns_d  = unsigned_i;
                    err_d  = acc_err;
                    cnt_d  = '0;
                    if (acc_err) begin
                        // Illegal access completes without touching memory.
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        req_d   = 1'b1;
                        we_d    = (func_i == FUNC_STORE);
                        addr_d  = eff_addr;
                        be_d    = be_new;
                        wdata_d = wdata_new;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem.dmem_ack_i) begin
                    req_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                    if (!we_q) begin
                        res_d = load_val;
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Request has been up for TIMEOUT cycles: give up.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            res_q   <= res_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_be_o    = be_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign done_o            = (state_q == ST_RESP);
    assign err_o             = (state_q == ST_RESP) && err_q;
    assign res_o             = res_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized operations,
// an in-bench memory responder and a scoreboard monitor.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst_ni;
    always #5 clk = ~clk;

    logic          valid;
    func_t         func;
    logic [1:0]    size;
    logic          uns;
    logic [DW-1:0] rs1, imm, rs2;
    logic          busy, done, err;
    logic [DW-1:0] res;
    state_t        state;

    load_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dmem ();

    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i      (clk),
        .arst_ni    (arst_ni),
        .valid_i    (valid),
        .func_i     (func),
        .size_i     (size),
        .unsigned_i (uns),
        .rs1_data_i (rs1),
        .imm_i      (imm),
        .rs2_data_i (rs2),
        .dmem       (dmem),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .res_o      (res),
        .state_o    (state)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] wdata;
        logic          we;
        int            req_len;
    } bus_t;

    typedef struct {
        logic [DW-1:0] rdata;
        int            dly;
    } rsp_t;

    logic [DW+1:0] exp_q[$];   // {request_was_issued, err, res}
    bus_t          bus_q[$];
    rsp_t          rsp_q[$];
    logic [DW-1:0] model_res = '0;
    bit            sb_off = 1'b0;
    int            n_vec = 0;
    int            n_miss = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // ---------------- reference model + driver ----------------
    task automatic do_op(input func_t f, input logic [1:0] sz, input logic u,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] d, input logic [DW-1:0] rdata,
                         input int dly);
        logic [AW-1:0]   ea;
        int              bytes, lane, guard;
        bit              bad, tmo, acted;
        longint unsigned mask, v;
        bus_t            bx;
        rsp_t            rx;

        ea    = a + b;
        bytes = 1 << sz;
        lane  = int'(ea % (DW / 8));
        bad   = ((ea % bytes) != 0) || (bytes > DW / 8);
        acted = (f == FUNC_LOAD) || (f == FUNC_STORE);
        tmo   = dly >= TO;
        mask  = (64'd1 << (8 * bytes)) - 64'd1;
        if (acted) begin
            if (bad) begin
                exp_q.push_back({1'b0, 1'b1, model_res});
            end else begin
                bx.addr    = ea;
                bx.be      = 4'(((1 << bytes) - 1) << lane);
                bx.wdata   = DW'((longint'(d) & mask) << (8 * lane));
                bx.we      = (f == FUNC_STORE);
                bx.req_len = tmo ? TO : dly + 1;
                bus_q.push_back(bx);
                rx.rdata = rdata;
                rx.dly   = dly;
                rsp_q.push_back(rx);
                if (!tmo && f == FUNC_LOAD) begin
                    v = (longint'(rdata) >> (8 * lane)) & mask;
                    if (!u && ((v >> (8 * bytes - 1)) & 64'd1) == 64'd1) v = v | ~mask;
                    model_res = DW'(v);
                end
                exp_q.push_back({1'b1, tmo, model_res});
            end
        end

        @(negedge clk);
        valid = 1'b1; func = f; size = sz; uns = u; rs1 = a; imm = b; rs2 = d;
        @(negedge clk);
        check("accept_busy", busy, acted);
        check("error_path_done", done, acted && bad);
        // Requests while busy must be ignored: feed garbage until idle.
        guard = 0;
        while (busy && guard < 100) begin
            valid = 1'($urandom_range(0, 1));
            func  = func_t'($urandom_range(0, 3));
            size  = 2'($urandom_range(0, 3));
            rs1   = $urandom; imm = $urandom; rs2 = $urandom;
            @(negedge clk);
            guard++;
        end
        valid = 1'b0;
        if (guard >= 100) fail("busy_never_cleared");
    endtask

    // ---------------- memory responder ----------------
    initial begin
        rsp_t r;
        int   k;
        dmem.dmem_ack_i   = 1'b0;
        dmem.dmem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (dmem.dmem_req_o && !sb_off && rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                k = 0;
                while (dmem.dmem_req_o && k < r.dly) begin
                    @(negedge clk);
                    k++;
                end
                if (dmem.dmem_req_o) begin
                    dmem.dmem_ack_i   = 1'b1;
                    dmem.dmem_rdata_i = r.rdata;
                    @(negedge clk);
                    // Occasional stray ack while no request is outstanding.
                    dmem.dmem_ack_i   = ($urandom_range(0, 2) == 0);
                    dmem.dmem_rdata_i = $urandom;
                    @(negedge clk);
                    dmem.dmem_ack_i   = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bus_t          cur;
    int            req_cnt = 0;
    logic          prev_req = 1'b0;
    logic [DW+1:0] e;

    always @(negedge clk) begin
        if (!sb_off) begin
            if (dmem.dmem_req_o && !prev_req) begin
                if (bus_q.size() == 0) begin
                    fail("unexpected_request");
                end else begin
                    cur = bus_q.pop_front();
                    req_cnt = 0;
                    check("req_addr", dmem.dmem_addr_o, cur.addr);
                    check("req_be", dmem.dmem_be_o, cur.be);
                    check("req_wdata", dmem.dmem_wdata_o, cur.wdata);
                    check("req_we", dmem.dmem_we_o, cur.we);
                end
            end
            if (dmem.dmem_req_o) begin
                req_cnt++;
                check("req_stable",
                      {dmem.dmem_addr_o, dmem.dmem_be_o, dmem.dmem_wdata_o, dmem.dmem_we_o},
                      {cur.addr, cur.be, cur.wdata, cur.we});
            end
            if (!dmem.dmem_req_o && prev_req) check("req_len", req_cnt, cur.req_len);
            if (done) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("done_err", err, e[DW]);
                    check("done_res", res, e[DW-1:0]);
                    check("done_after_req", prev_req, e[DW+1]);
                end
            end
            check("err_without_done", err && !done, 1'b0);
        end
        prev_req = dmem.dmem_req_o;
    end

    // ---------------- stimulus ----------------
    initial begin
        func_t fr;
        int    r;
        valid = 1'b0; func = FUNC_NONE; size = '0; uns = 1'b0;
        rs1 = '0; imm = '0; rs2 = '0;
        arst_ni = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs",
              {dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_be_o,
               dmem.dmem_wdata_o, busy, done, err, res},
              '0);
        @(posedge clk);
        #2 arst_ni = 1'b1;

        // Word load, ack after 3 cycles.
        do_op(FUNC_LOAD, 2'd2, 1'b0, 32'h100, 32'h4, 32'h0, 32'hDEAD_BEEF, 3);
        check("word_load_res", res, 32'hDEAD_BEEF);
        // Byte load, signed then unsigned.
        do_op(FUNC_LOAD, 2'd0, 1'b0, 32'h100, 32'h3, 32'h0, 32'h8000_0000, 0);
        check("byte_load_signed", res, 32'hFFFF_FF80);
        do_op(FUNC_LOAD, 2'd0, 1'b1, 32'h100, 32'h3, 32'h0, 32'h8000_0000, 1);
        check("byte_load_unsigned", res, 32'h0000_0080);
        // Half store in the upper lanes; result must not change.
        do_op(FUNC_STORE, 2'd1, 1'b0, 32'h200, 32'h2, 32'h1234_ABCD, 32'h5555_5555, 2);
        check("store_keeps_res", res, 32'h0000_0080);
        // Misaligned word and oversized access.
        do_op(FUNC_LOAD, 2'd2, 1'b0, 32'h100, 32'h1, 32'h0, 32'h0, 0);
        do_op(FUNC_LOAD, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 0);
        // Timeout, and ack on the very last allowed cycle.
        do_op(FUNC_LOAD, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 32'h1111_1111, 20);
        do_op(FUNC_LOAD, 2'd1, 1'b0, 32'h300, 32'h2, 32'h0, 32'hF00D_1234, TO - 1);
        // Address wrap-around.
        do_op(FUNC_STORE, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'hCAFE_F00D, 32'h0, 0);
        // Non-memory function codes are ignored.
        do_op(FUNC_NONE, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        do_op(FUNC_OTHER, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0);

        // Reset in the middle of a transaction, then a late ack.
        repeat (2) @(negedge clk);
        sb_off = 1'b1;
        valid = 1'b1; func = FUNC_LOAD; size = 2'd2; uns = 1'b0;
        rs1 = 32'h400; imm = 32'h0; rs2 = 32'h0;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_state", state, ST_WAIT);
        arst_ni = 1'b0;
        #1;
        check("mid_reset_outputs",
              {dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_be_o,
               dmem.dmem_wdata_o, busy, done, err, res},
              '0);
        @(negedge clk);
        arst_ni = 1'b1;
        dmem.dmem_ack_i = 1'b1; dmem.dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem.dmem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack_ignored", {done, busy, dmem.dmem_req_o, res}, '0);
            @(negedge clk);
        end
        model_res = '0;
        sb_off = 1'b0;
        // Release reset just before an edge and accept on that first edge.
        arst_ni = 1'b0;
        @(posedge clk);
        #2 arst_ni = 1'b1;
        do_op(FUNC_LOAD, 2'd2, 1'b1, 32'h500, 32'h8, 32'h0, 32'h0BAD_CAFE, 0);

        // Randomized operations.
        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            fr = (r < 5) ? FUNC_LOAD : (r < 9) ? FUNC_STORE : func_t'($urandom_range(0, 3));
            r  = $urandom_range(0, 15);
            do_op(fr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, DW'($urandom_range(0, 7)), $urandom, $urandom,
                  (r == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4));
        end

        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("bus_q_drained", bus_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum cycles dmem_req_o waits for dmem_ack_i; legal range 1..255.
REQ-004 SHALL provide one clock and an asynchronous active-low reset:
- clk_i  in  1  clock, all state updates on its rising edge.
- arst_ni  in  1  asynchronous reset, active low.
REQ-005 SHALL provide these ports:
- valid_i  in  1  operation request.
- func_i  in  func_t  operation; only LOAD and STORE are acted on.
- size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 double.
- unsigned_i  in  1  zero-extend load when 1, sign-extend when 0.
- rs1_data_i  in  DATA_WIDTH  base address.
- imm_i  in  DATA_WIDTH  address offset.
- rs2_data_i  in  DATA_WIDTH  store data.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  ADDR_WIDTH  byte address.
- dmem_be_o  out  DATA_WIDTH/8  byte enables.
- dmem_wdata_o  out  DATA_WIDTH  lane-aligned write data.
- dmem_rdata_i  in  DATA_WIDTH  read data, valid with ack.
- dmem_ack_i  in  1  memory acknowledge.
- busy_o  out  1  transaction in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  error qualifier, valid with done_o.
- res_o  out  DATA_WIDTH  load result, held until next done_o.

Function
REQ-006 SHALL implement FSM IDLE, WAIT, RESP; busy_o = 1 in WAIT and RESP.
REQ-007 In IDLE, valid_i=1 with func_i LOAD/STORE SHALL be accepted; other func_i values, and valid_i while not IDLE, SHALL be ignored.
REQ-008 Effective address SHALL be (rs1_data_i + imm_i) truncated to ADDR_WIDTH, wrap-around without error.
REQ-009 Access bytes = 1 << size_i; misaligned (address mod bytes != 0) or bytes > DATA_WIDTH/8 SHALL be an error.
REQ-010 Accepted legal access SHALL move to WAIT next cycle with dmem_req_o=1 and addr, we, be, wdata registered from the accept cycle.
REQ-011 Accepted erroneous access SHALL go to RESP with no request; done_o=1, err_o=1, res_o unchanged.
REQ-012 dmem_be_o SHALL have `bytes` ones starting at lane address mod (DATA_WIDTH/8); dmem_wdata_o SHALL place rs2_data_i low bytes in those lanes, other lanes 0.
REQ-013 dmem_req_o and all dmem outputs SHALL stay stable in WAIT until the cycle dmem_ack_i=1 is sampled; dmem_req_o SHALL be 0 from the next cycle.
REQ-014 On ack in WAIT, FSM SHALL go to RESP; for LOAD, res_o SHALL be the addressed lanes of dmem_rdata_i shifted to bit 0, sign- or zero-extended per unsigned_i; for STORE, res_o unchanged.
REQ-015 If no ack is sampled within TIMEOUT cycles of dmem_req_o rising, SHALL drop dmem_req_o and go to RESP with err_o=1.
REQ-016 RESP SHALL last exactly one cycle with done_o=1, then return to IDLE; new valid_i is accepted only in IDLE.
REQ-017 Minimum latency: accept cycle N, request at N+1, ack at N+1 gives done_o at N+2; error path gives done_o at N+1.
REQ-018 dmem_ack_i outside WAIT SHALL be ignored.
REQ-019 err_o SHALL be 0 whenever done_o is 0.

Reset
REQ-020 arst_ni=0 SHALL immediately force IDLE, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_be_o=0, dmem_wdata_o=0, busy_o=0, done_o=0, err_o=0, res_o=0, timeout counter 0.
REQ-021 Reset mid-transaction SHALL abandon it with no done_o; a later ack SHALL be ignored.
REQ-022 Leaving reset SHALL accept valid_i at the first rising edge with arst_ni=1.

Verification
REQ-023 Word load: rs1=0x100, imm=0x4, size=2, rdata=0xDEADBEEF, ack after 3 cycles -> addr 0x104, be 0xF, res_o=0xDEADBEEF, done_o one cycle.
REQ-024 Signed byte load: addr 0x103, rdata=0x80000000 -> be 0x8, res_o=0xFFFFFF80; with unsigned_i=1 -> 0x00000080.
REQ-025 Half store: addr 0x202, rs2=0x1234ABCD -> be 0xC, wdata=0xABCD0000, we=1, err_o=0.
REQ-026 Misaligned word at 0x101 -> no dmem_req_o, done_o and err_o next cycle; size=3 with DATA_WIDTH=32 -> same.
REQ-027 No ack with TIMEOUT=16 -> dmem_req_o high exactly 16 cycles, then done_o=1, err_o=1.
REQ-028 Reset asserted in WAIT, then ack pulse -> no done_o, all outputs zero, next valid_i accepted normally.
